// File: rtl/mdu_ctrl.sv
// mdu_ctrl
// Sequencer for the multi-cycle multiply/divide unit and its HI/LO register
// pair in the E stage. It accepts MD issues from E and models the operation
// latency with a busy counter. It commits results to HI/LO, raises the D-stage
// stall for MD-class instructions, and supplies HI/LO read data for mfhi/mflo.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous reset, active low (0 = reset asserted)
//   start     E-stage MD instruction valid this cycle
//   md_op     0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 no-op
//   A, B      forwarded rs / rt values
//   md_d      D-stage instruction is MD-class
//   rd_hi     read select for rdata (1 = HI, 0 = LO)
//   busy      multiply/divide in progress
//   md_stall  stall request to the hazard unit
//   HI, LO    committed HI/LO registers
//   rdata     committed HI or LO, selected by rd_hi
//
// Optional feature: define MDU_DIV_ZERO_KEEP_EN to leave HI/LO untouched when
// a div/divu with B == 0 commits. The operation still takes the full busy time.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        md_d,
  input  logic        rd_hi,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] rdata
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {IDLE, MULT, DIV} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [31:0]   pend_hi, pend_lo, pend_hi_next, pend_lo_next;
  logic [31:0]   hi_next, lo_next;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        quot, rem;

  assign prod_s = $signed(A) * $signed(B);
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Divider result for the issuing div/divu. A zero divisor yields a defined
  // pattern (all-ones quotient, dividend as remainder) rather than X.
  always_comb begin
    quot = 32'hFFFF_FFFF;
    rem  = A;
    if (B != 32'd0) begin
      if (!md_op[0]) begin
        quot = $signed(A) / $signed(B);
        rem  = $signed(A) % $signed(B);
      end else begin
        quot = A / B;
        rem  = A % B;
      end
    end
  end

  // Next-state logic: issue from IDLE, count down while busy, commit at zero.
  // A start arriving while busy falls through with every register held.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    pend_hi_next = pend_hi;
    pend_lo_next = pend_lo;
    hi_next      = HI;
    lo_next      = LO;
    case (state)
      IDLE: begin
        if (start) begin
          case (md_op)
            3'd0: begin
              {pend_hi_next, pend_lo_next} = prod_s;
              state_next = MULT;
              cnt_next   = CW'(MULT_CYCLES - 1);
            end
            3'd1: begin
              {pend_hi_next, pend_lo_next} = prod_u;
              state_next = MULT;
              cnt_next   = CW'(MULT_CYCLES - 1);
            end
            3'd2, 3'd3: begin
`ifdef MDU_DIV_ZERO_KEEP_EN
              // HI/LO cannot change while busy, so the current values
              // become the pending result and the commit is a no-op.
              if (B == 32'd0) begin
                pend_hi_next = HI;
                pend_lo_next = LO;
              end else begin
                pend_hi_next = rem;
                pend_lo_next = quot;
              end
`else
              pend_hi_next = rem;
              pend_lo_next = quot;
`endif
              state_next = DIV;
              cnt_next   = CW'(DIV_CYCLES - 1);
            end
            3'd4: hi_next = A;
            3'd5: lo_next = A;
            default: ;
          endcase
        end
      end
      MULT, DIV: begin
        if (cnt == '0) begin
          hi_next    = pend_hi;
          lo_next    = pend_lo;
          state_next = IDLE;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      HI      <= 32'd0;
      LO      <= 32'd0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      pend_hi <= pend_hi_next;
      pend_lo <= pend_lo_next;
      HI      <= hi_next;
      LO      <= lo_next;
    end
  end

  assign busy     = (state != IDLE);
  assign md_stall = md_d & (busy | start);
  assign rdata    = rd_hi ? HI : LO;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl
// Directed self-checking bench for mdu_ctrl with default parameters. It checks
// reset, mthi/mtlo, mult/multu, div/divu, stall generation, and that a start is
// ignored while busy. It also checks reset in the middle of a divide and, when
// MDU_DIV_ZERO_KEEP_EN is defined, divide-by-zero preservation.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a, b;
  logic        md_d;
  logic        rd_hi;
  logic        busy, md_stall;
  logic [31:0] hi, lo, rdata;

  int errors = 0;
  int checks = 0;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(a), .B(b),
    .md_d(md_d), .rd_hi(rd_hi), .busy(busy), .md_stall(md_stall),
    .HI(hi), .LO(lo), .rdata(rdata)
  );

  always #5 clk = ~clk;

  // Step to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one MD op and count the busy cycles that follow (bounded).
  task automatic run_op(input logic [2:0] op, input logic [31:0] av, bv,
                        output int cycles);
    start = 1'b1; md_op = op; a = av; b = bv;
    tick();
    start = 1'b0;
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; md_op = 3'd7; a = '0; b = '0; md_d = 1'b0; rd_hi = 1'b0;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if (hi !== 32'd0) begin errors++; $display("[TB] FAIL reset_hi: got %h want 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("[TB] FAIL reset_lo: got %h want 0", lo); end
    checks++; if (md_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b want 0", md_stall); end
    reset = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_mthi_mtlo();
    start = 1'b1; md_op = 3'd4; a = 32'h1234_5678;
    tick();
    md_op = 3'd5; a = 32'h9ABC_DEF0;
    checks++; if (hi !== 32'h1234_5678) begin errors++; $display("[TB] FAIL mthi_hi: got %h want 12345678", hi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mthi_busy: got %b want 0", busy); end
    tick();
    start = 1'b0; md_op = 3'd7;
    checks++; if (lo !== 32'h9ABC_DEF0) begin errors++; $display("[TB] FAIL mtlo_lo: got %h want 9abcdef0", lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mtlo_busy: got %b want 0", busy); end
    rd_hi = 1'b1; #1;
    checks++; if (rdata !== 32'h1234_5678) begin errors++; $display("[TB] FAIL rdata_hi: got %h want 12345678", rdata); end
    rd_hi = 1'b0; #1;
    checks++; if (rdata !== 32'h9ABC_DEF0) begin errors++; $display("[TB] FAIL rdata_lo: got %h want 9abcdef0", rdata); end
  endtask

  task automatic test_mult();
    int cyc;
    run_op(3'd0, 32'hFFFF_FFFF, 32'd2, cyc);
    checks++; if (cyc != 5) begin errors++; $display("[TB] FAIL mult_cycles: got %0d want 5", cyc); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL mult_hi: got %h want ffffffff", hi); end
    checks++; if (lo !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL mult_lo: got %h want fffffffe", lo); end
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, cyc);
    checks++; if (cyc != 5) begin errors++; $display("[TB] FAIL multu_cycles: got %0d want 5", cyc); end
    checks++; if (hi !== 32'h0000_0001) begin errors++; $display("[TB] FAIL multu_hi: got %h want 00000001", hi); end
    checks++; if (lo !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL multu_lo: got %h want fffffffe", lo); end
  endtask

  task automatic test_div();
    int cyc;
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, cyc);
    checks++; if (cyc != 10) begin errors++; $display("[TB] FAIL div_cycles: got %0d want 10", cyc); end
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("[TB] FAIL div_lo: got %h want fffffffd", lo); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL div_hi: got %h want ffffffff", hi); end
    run_op(3'd3, 32'd7, 32'd2, cyc);
    checks++; if (cyc != 10) begin errors++; $display("[TB] FAIL divu_cycles: got %0d want 10", cyc); end
    checks++; if (lo !== 32'd3) begin errors++; $display("[TB] FAIL divu_lo: got %h want 00000003", lo); end
    checks++; if (hi !== 32'd1) begin errors++; $display("[TB] FAIL divu_hi: got %h want 00000001", hi); end
  endtask

  task automatic test_stall_ignore();
    int stall_cyc;
    int guard;
    // HI=1, LO=3 from divu; issue mult 0x12345 * 0x10000 = 0x1_23450000
    md_d = 1'b1; start = 1'b1; md_op = 3'd0; a = 32'h0001_2345; b = 32'h0001_0000;
    #1;
    checks++; if (md_stall !== 1'b1) begin errors++; $display("[TB] FAIL stall_issue: got %b want 1", md_stall); end
    tick();
    start = 1'b0;
    checks++; if (hi !== 32'd1) begin errors++; $display("[TB] FAIL pending_hidden: got %h want 00000001", hi); end
    stall_cyc = 0;
    if (busy === 1'b1 && md_stall === 1'b1) stall_cyc++;
    // stray mult 5*5 while busy must be ignored
    start = 1'b1; md_op = 3'd0; a = 32'd5; b = 32'd5;
    tick();
    start = 1'b0;
    guard = 0;
    while (busy === 1'b1 && guard < 100) begin
      if (md_stall === 1'b1) stall_cyc++;
      guard++;
      tick();
    end
    checks++; if (stall_cyc != 5) begin errors++; $display("[TB] FAIL stall_cycles: got %0d want 5", stall_cyc); end
    checks++; if (md_stall !== 1'b0) begin errors++; $display("[TB] FAIL stall_after: got %b want 0", md_stall); end
    checks++; if (hi !== 32'd1) begin errors++; $display("[TB] FAIL ignore_hi: got %h want 00000001", hi); end
    checks++; if (lo !== 32'h2345_0000) begin errors++; $display("[TB] FAIL ignore_lo: got %h want 23450000", lo); end
    md_d = 1'b0;
  endtask

  task automatic test_reset_mid_div();
    start = 1'b1; md_op = 3'd3; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0;
    repeat (5) tick();  // counter now at 4
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL middiv_busy: got %b want 1", busy); end
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL middiv_rst_busy: got %b want 0", busy); end
    checks++; if (hi !== 32'd0) begin errors++; $display("[TB] FAIL middiv_rst_hi: got %h want 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("[TB] FAIL middiv_rst_lo: got %h want 0", lo); end
    tick();
    reset = 1'b1;
    repeat (12) tick();
    rd_hi = 1'b0; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL middiv_after_busy: got %b want 0", busy); end
    checks++; if (rdata !== 32'd0) begin errors++; $display("[TB] FAIL middiv_mflo: got %h want 0", rdata); end
    checks++; if (hi !== 32'd0) begin errors++; $display("[TB] FAIL middiv_after_hi: got %h want 0", hi); end
  endtask

`ifdef MDU_DIV_ZERO_KEEP_EN
  task automatic test_div_zero();
    int cyc;
    start = 1'b1; md_op = 3'd4; a = 32'hAAAA_0000;
    tick();
    md_op = 3'd5; a = 32'h0000_BBBB;
    tick();
    start = 1'b0;
    run_op(3'd2, 32'd5, 32'd0, cyc);
    checks++; if (cyc != 10) begin errors++; $display("[TB] FAIL divzero_cycles: got %0d want 10", cyc); end
    checks++; if (hi !== 32'hAAAA_0000) begin errors++; $display("[TB] FAIL divzero_hi: got %h want aaaa0000", hi); end
    checks++; if (lo !== 32'h0000_BBBB) begin errors++; $display("[TB] FAIL divzero_lo: got %h want 0000bbbb", lo); end
  endtask
`endif

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_mult();
    test_div();
    test_stall_ignore();
    test_reset_mid_div();
`ifdef MDU_DIV_ZERO_KEEP_EN
    test_div_zero();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Sequencer for the multi-cycle multiply/divide unit and its HI/LO register pair in the E stage of the 5-stage pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo issues from E, models the MULT_CYCLES/DIV_CYCLES latency with a busy counter, and commits results to HI/LO.
- Drives the D-stage stall for MD-class instructions. The stall is ORed with the existing RS/RT stall.
- Supplies HI/LO read data for mfhi/mflo. That data feeds the E-stage forwarding/result path.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous active-low reset; 0 = reset asserted
start  input  1  E-stage MD instruction valid this cycle
md_op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 no-op
A  input  32  forwarded rs value (E stage)
B  input  32  forwarded rt value (E stage)
md_d  input  1  D-stage instruction is MD-class (mult..mtlo, mfhi, mflo)
rd_hi  input  1  read select: 1 = HI, 0 = LO
busy  output  1  operation in progress
md_stall  output  1  stall request to hazard unit
HI  output  32  HI register
LO  output  32  LO register
rdata  output  32  rd_hi ? HI : LO (combinational)

Behaviour:
- Reset (reset==0, async):
  - state=IDLE, cnt=0, HI=0, LO=0, pending HI/LO=0, busy=0.
  - Reset mid-operation aborts the operation and discards the pending result.
- States: IDLE, MULT, DIV. busy = (state != IDLE), registered.
- IDLE, start=1, md_op 0/1 (edge t):
  - pending_{HI,LO} <= 64-bit product: signed for op 0, unsigned for op 1.
  - state <= MULT, cnt <= MULT_CYCLES-1.
- IDLE, start=1, md_op 2/3:
  - pending_LO <= quotient, pending_HI <= remainder.
  - Signed for op 2: truncate toward zero, remainder takes the dividend's sign. Unsigned for op 3.
  - state <= DIV, cnt <= DIV_CYCLES-1.
- MULT/DIV each cycle:
  - If cnt==0: HI/LO <= pending, state <= IDLE.
  - Else cnt <= cnt-1.
  - busy is high for exactly MULT_CYCLES or DIV_CYCLES cycles, starting the cycle after the start edge. The new HI/LO is visible in the first cycle with busy=0.
- IDLE, start=1, md_op 4: HI <= A at the edge, no busy. md_op 5: LO <= A likewise. md_op 6/7: no effect.
- start while busy:
  - Ignored entirely. State, counter, pending and HI/LO are unchanged.
  - Cannot occur in a correct pipeline because md_stall prevents it.
- md_stall = md_d & (busy | start). This holds back a D-stage MD instruction while an MD op is in flight or issuing in E this cycle.
- rdata reflects committed HI/LO only, never pending values.
- Counter width: clog2(max(MULT_CYCLES, DIV_CYCLES)). No wrap; cnt only decrements from a loaded value to 0.
- Division by zero: timing identical to a normal div, with busy for DIV_CYCLES. HI/LO contents are governed by the optional feature.

Optional Feature:
- Macro MDU_DIV_ZERO_KEEP_EN.
- Defined: div/divu with B==0 still runs DIV_CYCLES busy cycles, but the commit leaves HI and LO unchanged (pending load suppressed).
- Undefined: the commit writes whatever the divider produced. HI/LO are unspecified after div-by-zero and the bench must not check them.

Test Plan:
- Reset low mid-DIV (cnt=4), then release -> busy=0, HI=0, LO=0 next cycle; a later mflo reads 0.
- mult A=0xFFFFFFFF, B=2, default params -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- div A=-7 (0xFFFFFFF9), B=2 -> busy high 10 cycles; then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu A=7, B=2 -> LO=3, HI=1.
- mthi A=0x12345678, then mtlo A=0x9ABCDEF0 in the next cycle -> no busy; HI/LO updated on the following edges; rdata correct for rd_hi=1/0.
- mult issues (start=1) with md_d=1 the same cycle -> md_stall=1 that cycle and all 5 busy cycles, 0 after. A second start during busy leaves HI/LO equal to the first result.
- With MDU_DIV_ZERO_KEEP_EN: HI=0xAAAA0000 and LO=0x0000BBBB preset, div with B=0 -> busy 10 cycles, HI/LO unchanged.
